// File: rtl/game_pkg.sv
// Shared game constants: HP widths, round-state encodings and the boss damage helper.
// The game-state handler imports the same package so both sides agree on encodings.
package game_pkg;

  localparam int BOSS_HP_W   = 10;
  localparam int PLAYER_HP_W = 2;

  localparam logic [1:0] GS_PLAYING = 2'b00;
  localparam logic [1:0] GS_WIN     = 2'b01;
  localparam logic [1:0] GS_LOSE    = 2'b10;

  // Saturating subtract: a hit that would take HP to or below zero leaves exactly zero.
  function automatic logic [BOSS_HP_W-1:0] boss_after_hit(
    input logic [BOSS_HP_W-1:0] hp,
    input logic [BOSS_HP_W-1:0] dmg
  );
    return (hp <= dmg) ? '0 : (hp - dmg);
  endfunction

endpackage

// File: rtl/hp_tracker_if.sv
// Signals between collision logic / game-state handler (master) and hp_tracker (slave).
interface hp_tracker_if;
  import game_pkg::*;

  // No handshake: hit inputs are levels sampled every clock, gameState is a level from
  // the handler, and all outputs are registered levels valid every cycle.
  logic [1:0]             gameState;
  logic                   bossHit;
  logic                   playerHit;
  logic [BOSS_HP_W-1:0]   bossHP;
  logic [PLAYER_HP_W-1:0] playerHP;
  logic                   playerInvuln;
  logic                   bossFlash;

  modport master (
    output gameState, bossHit, playerHit,
    input  bossHP, playerHP, playerInvuln, bossFlash
  );

  modport slave (
    input  gameState, bossHit, playerHit,
    output bossHP, playerHP, playerInvuln, bossFlash
  );

endinterface

// File: rtl/countdown_timer.sv
// Reloadable down-counter: `active` is high for exactly CYCLES unheld cycles after a load.
module countdown_timer #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic hold,
  output logic active
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES);

  logic [W-1:0] cnt_q, cnt_d;
  logic         active_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Flag tracks the next count so it rises with the load edge and falls after CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= (cnt_d != '0);
    end
  end

  assign active = active_q;

endmodule

// File: rtl/hp_tracker.sv
// Boss/player HP registers: edge-detected hits, invulnerability and flash windows, freeze at round end.
module hp_tracker
  import game_pkg::*;
#(
  parameter int BOSS_HP_MAX   = 1000,
  parameter int PLAYER_HP_MAX = 3,
  parameter int BOSS_DMG      = 10,
  parameter int INVULN_CYCLES = 50_000_000,
  parameter int FLASH_CYCLES  = 5_000_000
) (
  input  logic         clk,
  input  logic         rst,
  hp_tracker_if.slave  bus
);

  localparam logic [BOSS_HP_W-1:0]   BOSS_MAX_V   = BOSS_HP_W'(BOSS_HP_MAX);
  localparam logic [PLAYER_HP_W-1:0] PLAYER_MAX_V = PLAYER_HP_W'(PLAYER_HP_MAX);
  localparam logic [BOSS_HP_W-1:0]   BOSS_DMG_V   = BOSS_HP_W'(BOSS_DMG);

  logic [BOSS_HP_W-1:0]   boss_hp_q, boss_hp_d;
  logic [PLAYER_HP_W-1:0] player_hp_q, player_hp_d;
  logic                   boss_prev_q, player_prev_q;

  logic invuln, flash;
  logic frozen, boss_ev, player_ev;
  logic boss_take, boss_kill, player_take;

  // HP terms cover the cycle before the handler reacts to a zero.
  always_comb begin
    frozen      = (bus.gameState != GS_PLAYING) || (boss_hp_q == '0) || (player_hp_q == '0);
    boss_ev     = bus.bossHit & ~boss_prev_q;
    player_ev   = bus.playerHit & ~player_prev_q;
    boss_take   = boss_ev & ~frozen;
    boss_kill   = boss_take & (boss_hp_q <= BOSS_DMG_V);
    player_take = player_ev & ~frozen & ~invuln & ~boss_kill;
  end

  always_comb begin
    boss_hp_d   = boss_hp_q;
    player_hp_d = player_hp_q;
    if (boss_take) begin
      boss_hp_d = boss_after_hit(boss_hp_q, BOSS_DMG_V);
    end
    if (player_take) begin
      player_hp_d = player_hp_q - PLAYER_HP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      boss_hp_q     <= BOSS_MAX_V;
      player_hp_q   <= PLAYER_MAX_V;
      boss_prev_q   <= 1'b0;
      player_prev_q <= 1'b0;
    end else begin
      boss_hp_q     <= boss_hp_d;
      player_hp_q   <= player_hp_d;
      boss_prev_q   <= bus.bossHit;
      player_prev_q <= bus.playerHit;
    end
  end

  countdown_timer #(.CYCLES(INVULN_CYCLES)) u_invuln (
    .clk    (clk),
    .rst    (rst),
    .load   (player_take),
    .hold   (frozen),
    .active (invuln)
  );

  countdown_timer #(.CYCLES(FLASH_CYCLES)) u_flash (
    .clk    (clk),
    .rst    (rst),
    .load   (boss_take),
    .hold   (frozen),
    .active (flash)
  );

  assign bus.bossHP       = boss_hp_q;
  assign bus.playerHP     = player_hp_q;
  assign bus.playerInvuln = invuln;
  assign bus.bossFlash    = flash;

endmodule
